// File: rtl/load_store_unit_seq.sv
// -----------------------------------------------------------------------------
// load_store_unit_seq
//   Multi-cycle load/store unit. Takes one request at a time from the core,
//   forms EA = base + sext(imm12), and drives a valid/ready memory port with
//   byte enables. An access that crosses a beat boundary is either split into
//   two aligned beats (ALLOW_MISALIGNED=1) or reported as a fault. Load data
//   from one or two beats is merged, truncated to the access size and sign- or
//   zero-extended. Exactly one response pulse is returned per request.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake (ready only when idle)
//   req_store, req_funct3          access kind and RISC-V funct3
//   req_base, req_imm              rs1 value and 12-bit immediate
//   req_wdata, req_rd              store data, load destination register
//   mem_valid/mem_ready            memory beat handshake
//   mem_we, mem_addr, mem_be       beat direction, aligned address, lane enables
//   mem_wdata                      store data rotated into its byte lanes
//   mem_rvalid, mem_rdata          read data, one per accepted read beat
//   rsp_valid, rsp_rd, rsp_data    one-cycle response with echoed rd and data
//   rsp_werf, rsp_fault            register-file write enable, fault flag
// -----------------------------------------------------------------------------
module load_store_unit_seq #(
   parameter int XLEN             = 32,
   parameter int ADDR_W           = 32,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_store,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_W-1:0]     req_base,
   input  logic [11:0]           req_imm,
   input  logic [XLEN-1:0]       req_wdata,
   input  logic [4:0]            req_rd,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [XLEN/8-1:0]     mem_be,
   output logic [XLEN-1:0]       mem_wdata,
   input  logic                  mem_rvalid,
   input  logic [XLEN-1:0]       mem_rdata,
   output logic                  rsp_valid,
   output logic [4:0]            rsp_rd,
   output logic [XLEN-1:0]       rsp_data,
   output logic                  rsp_werf,
   output logic                  rsp_fault
);

   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE0,
      S_WAIT0,
      S_ISSUE1,
      S_WAIT1,
      S_RESP
   } state_t;

   state_t state, state_nxt;

   // ---------------------------------------------------------------------------
   // Request decode (combinational on the incoming request fields)
   // ---------------------------------------------------------------------------
   logic [ADDR_W-1:0] ea;
   logic [OW-1:0]     off_in;
   logic [3:0]        size_in;
   logic [4:0]        span_in;     // off + size, in bytes
   logic              legal_in;
   logic              split_in;
   logic              fault_in;
   logic [2*NB-1:0]   mask_in;     // lane enables across both beats
   logic [OW+2:0]     wsh;
   logic [XLEN-1:0]   wdata_rot_in;

   assign ea       = req_base + {{(ADDR_W-12){req_imm[11]}}, req_imm};
   assign off_in   = ea[OW-1:0];
   assign size_in  = 4'd1 << req_funct3[1:0];
   assign span_in  = 5'(off_in) + 5'(size_in);
   assign split_in = span_in > 5'(NB);
   assign fault_in = !legal_in || (split_in && !ALLOW_MISALIGNED);
   assign wsh      = {off_in, 3'b000};

   // Rotating (not shifting) lets both beats of a split store drive the same word.
   assign wdata_rot_in = (req_wdata << wsh) | (req_wdata >> (XLEN - int'(wsh)));

   // NOTE: every signal driven in an always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      legal_in = 1'b0;
      unique case (req_funct3)
         3'b000, 3'b001, 3'b010: legal_in = 1'b1;
         3'b011:                 legal_in = (XLEN == 64);
         3'b100, 3'b101:         legal_in = !req_store;
         3'b110:                 legal_in = !req_store && (XLEN == 64);
         default:                legal_in = 1'b0;
      endcase
   end

   always_comb begin
      mask_in = '0;
      for (int i = 0; i < 2*NB; i++) begin
         mask_in[i] = (i >= int'(off_in)) && (i < int'(span_in));
      end
   end

   // ---------------------------------------------------------------------------
   // Registered request and load-data buffer
   // ---------------------------------------------------------------------------
   logic                st_r;
   logic                sext_r;
   logic [3:0]          size_r;
   logic [OW-1:0]       off_r;
   logic                fault_r;
   logic                split_r;
   logic [ADDR_W-1:0]   addr0_r;
   logic [NB-1:0]       be0_r;
   logic [NB-1:0]       be1_r;
   logic [XLEN-1:0]     wdata_r;
   logic [4:0]          rd_r;
   logic [2*XLEN-1:0]   rbuf_r;     // {beat1, beat0} read data

   logic accept, cap0, cap1;

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // values from before the edge, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_r    <= 1'b0;
         sext_r  <= 1'b0;
         size_r  <= 4'd0;
         off_r   <= '0;
         fault_r <= 1'b0;
         split_r <= 1'b0;
         addr0_r <= '0;
         be0_r   <= '0;
         be1_r   <= '0;
         wdata_r <= '0;
         rd_r    <= 5'd0;
         rbuf_r  <= '0;
      end else begin
         if (accept) begin
            st_r    <= req_store;
            sext_r  <= !req_funct3[2];
            size_r  <= size_in;
            off_r   <= off_in;
            fault_r <= fault_in;
            split_r <= split_in;
            addr0_r <= {ea[ADDR_W-1:OW], {OW{1'b0}}};
            be0_r   <= mask_in[NB-1:0];
            be1_r   <= mask_in[2*NB-1:NB];
            wdata_r <= wdata_rot_in;
            rd_r    <= req_rd;
            rbuf_r  <= '0;
         end
         if (cap0) rbuf_r[XLEN-1:0]      <= mem_rdata;
         if (cap1) rbuf_r[2*XLEN-1:XLEN] <= mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // ---------------------------------------------------------------------------
   // Next state and memory-port outputs. Memory outputs are decoded from the
   // state so they fall to zero immediately on reset and stay stable while a
   // beat waits for mem_ready.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      mem_valid = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      cap0      = 1'b0;
      cap1      = 1'b0;
      unique case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = fault_in ? S_RESP : S_ISSUE0;
            end
         end
         S_ISSUE0: begin
            mem_valid = 1'b1;
            mem_we    = st_r;
            mem_addr  = addr0_r;
            mem_be    = be0_r;
            mem_wdata = st_r ? wdata_r : '0;
            if (mem_ready) begin
               if (st_r) state_nxt = split_r ? S_ISSUE1 : S_RESP;
               else      state_nxt = S_WAIT0;
            end
         end
         S_WAIT0: begin
            if (mem_rvalid) begin
               cap0      = 1'b1;
               state_nxt = split_r ? S_ISSUE1 : S_RESP;
            end
         end
         S_ISSUE1: begin
            mem_valid = 1'b1;
            mem_we    = st_r;
            mem_addr  = addr0_r + ADDR_W'(NB);   // wraps at 2^ADDR_W
            mem_be    = be1_r;
            mem_wdata = st_r ? wdata_r : '0;
            if (mem_ready) state_nxt = st_r ? S_RESP : S_WAIT1;
         end
         S_WAIT1: begin
            if (mem_rvalid) begin
               cap1      = 1'b1;
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Load merge: shifting the two-beat buffer right by off lines beat0 bytes
   // [off..NB-1] up at result byte 0 with beat1 bytes directly above them.
   // ---------------------------------------------------------------------------
   logic [XLEN-1:0] merged;
   logic [XLEN-1:0] load_ext;
   logic            msb;

   assign merged = XLEN'(rbuf_r >> {off_r, 3'b000});

   always_comb begin
      msb      = 1'b0;
      load_ext = '0;
      unique case (size_r)
         4'd1:    msb = merged[7];
         4'd2:    msb = merged[15];
         4'd4:    msb = merged[31];
         default: msb = merged[XLEN-1];
      endcase
      for (int b = 0; b < XLEN; b++) begin
         load_ext[b] = (b < 8*int'(size_r)) ? merged[b] : (sext_r & msb);
      end
   end

   assign rsp_rd    = rsp_valid ? rd_r : 5'd0;
   assign rsp_fault = rsp_valid && fault_r;
   assign rsp_werf  = rsp_valid && !fault_r && !st_r && (rd_r != 5'd0);
   assign rsp_data  = (rsp_valid && !fault_r && !st_r) ? load_ext : '0;

endmodule
